cascade_modn_counter: RTL
=========================

# cascade_modn_counter

Parametrised chain of modulo-N digit counters for the stopwatch datapath. It generalises the single fixed mod-5 digit into DIGITS cascaded 4-bit digits, each with its own modulus. It adds up/down counting, parallel load, sticky overflow and a lap-capture register. It sits between the tick prescaler and the display multiplexer, and its carry output can feed a further chain.

## Interface
- DIGITS, 4, number of cascaded digits (1..8); digit 0 is least significant and occupies bits [3:0].
- MODULI, 16'h6A6A, packed per-digit modulus, 4 bits per digit; encoding 2..15 is the literal modulus, 0 means 16, and 1 is illegal. The default gives digit moduli 10, 6, 10, 6 (from digit 0 up), i.e. MM:SS.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  count tick; one step per cycle while high.
- up_down  input  1  1 = count up, 0 = count down.
- clear  input  1  synchronous clear of count and overflow.
- load  input  1  synchronous parallel load.
- load_value  input  4*DIGITS  value to load.
- lap  input  1  capture current count into lap_count.
- count  output  4*DIGITS  registered count.
- lap_count  output  4*DIGITS  registered lap snapshot.
- lap_valid  output  1  one-cycle pulse after a capture.
- carry_out  output  1  combinational chain carry/borrow.
- overflow  output  1  sticky wrap indicator.

## Operation
- Terminal value per digit: M-1 when counting up, 0 when counting down, where M is that digit's modulus.
- Digit k steps on an enabled edge when all digits below k are at terminal; digit 0 steps on every enabled edge.
- A digit stepping from its terminal value wraps: to 0 when up, to M-1 when down.
- carry_out = enable AND every digit at terminal, evaluated with the current up_down.
- overflow sets on any enabled edge where carry_out=1. It is cleared only by reset, clear or load.
- Priority on each edge: reset > clear > load > enable.
- clear forces count=0 and overflow=0.
- load writes load_value digit by digit. Any digit >= its modulus loads as M-1 (clamp). load also forces overflow=0.
- Changing up_down takes effect on the next enabled edge. No extra state is involved.
- lap=1 on an edge stores the pre-edge count into lap_count, then raises lap_valid for the following cycle.
  - This holds regardless of clear, load or enable on the same edge.
  - lap held high captures on every edge and holds lap_valid high.
- reset low immediately forces count=0, lap_count=0, lap_valid=0 and overflow=0. Capture and count are inhibited while reset is low.
- Elaboration fails if any modulus encoding is 1 or DIGITS is outside 1..8.

## Timing
- count, overflow, lap_count and lap_valid update on the rising clk edge; their latency is 1 cycle from the inputs.
- carry_out is combinational from the registered count, enable and up_down, so it is valid in the same cycle as enable. This allows a downstream chain to be enabled by it without a cycle of lag.
- Reset assertion is asynchronous.
- Reset deassertion must be synchronous to clk, handled externally. The first counting edge is the first rising edge with reset high and enable high.
- No multi-cycle paths; the whole chain's carry logic resolves within one clock period.

## Test plan
- Reset mid-count: at count 16'h0347, drive reset low between edges → count, lap_count and overflow read 0 immediately. After release, holding enable low keeps count at 0.
- Cascade up: from 0, apply 10 enables → 16'h0010. Apply 60 enables from 0 → 16'h0100. Apply 3599 enables → 16'h5959 with overflow=0.
- Up wrap: load 16'h5959, up_down=1, one enable → carry_out=1 during that cycle. After the edge, count is 16'h0000 and overflow=1.
- Down borrow: clear, then up_down=0, one enable → carry_out=1, count 16'h5959, overflow=1. A further enable gives 16'h5958.
- Load clamp: load 16'h0F9F → count 16'h0959 (digit0 F→9, digit1 9→5, digit2 F→9) and overflow=0.
- Lap with clear: at count 16'h0123, assert lap and clear on the same edge → lap_count 16'h0123 and count 16'h0000. lap_valid is 1 for exactly one cycle.

Source files
------------

// File: rtl/cascade_modn_counter.sv
// Cascaded chain of 4-bit modulo-N digits with up/down count, clamped parallel load,
// sticky overflow and a lap-capture snapshot; carry_out is combinational for chaining.
module cascade_modn_counter #(
  parameter int unsigned           DIGITS = 4,
  parameter logic [4*DIGITS-1:0]   MODULI = 16'h6A6A
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   lap_count,
  output logic                  lap_valid,
  output logic                  carry_out,
  output logic                  overflow
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]      r_count;
  logic [W-1:0]      r_lap_count;
  logic              r_lap_valid;
  logic              r_overflow;

  logic [W-1:0]      w_count_adv;
  logic [W-1:0]      w_count_load;
  logic [W-1:0]      w_count_nxt;
  logic              w_overflow_nxt;
  logic [DIGITS-1:0] w_term;
  logic [DIGITS-1:0] w_step;
  logic              w_all_term;

  if (DIGITS == 0 || DIGITS > 8) begin : g_bad_digits
    $error("cascade_modn_counter: DIGITS must be in 1..8");
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    // Encoding 0 means modulus 16, so ENC-1 wraps to 15 as the up-count terminal.
    localparam logic [3:0] ENC  = MODULI[4*k +: 4];
    localparam logic [3:0] MAXV = ENC - 4'd1;

    if (ENC == 4'd1) begin : g_bad_mod
      $error("cascade_modn_counter: modulus encoding 1 is illegal");
    end

    logic [3:0] w_cur;
    logic [3:0] w_ld;

    assign w_cur     = r_count[4*k +: 4];
    assign w_ld      = load_value[4*k +: 4];
    assign w_term[k] = up_down ? (w_cur == MAXV) : (w_cur == 4'd0);

    if (k == 0) begin : g_lsd
      assign w_step[k] = 1'b1;
    end else begin : g_upper
      assign w_step[k] = &w_term[k-1:0];
    end

    assign w_count_adv[4*k +: 4] =
      !w_step[k] ? w_cur :
      w_term[k]  ? (up_down ? 4'd0 : MAXV) :
                   (up_down ? w_cur + 4'd1 : w_cur - 4'd1);

    assign w_count_load[4*k +: 4] = (w_ld > MAXV) ? MAXV : w_ld;
  end

  assign w_all_term = &w_term;
  assign carry_out  = enable & w_all_term;

  // Edge priority: clear > load > enable.
  always_comb begin
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    if (clear) begin
      w_count_nxt    = '0;
      w_overflow_nxt = 1'b0;
    end else if (load) begin
      w_count_nxt    = w_count_load;
      w_overflow_nxt = 1'b0;
    end else if (enable) begin
      w_count_nxt    = w_count_adv;
      w_overflow_nxt = r_overflow | w_all_term;
    end
  end

  // Lap capture samples the pre-edge count independently of clear/load/enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_lap_count <= '0;
      r_lap_valid <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_overflow  <= w_overflow_nxt;
      r_lap_valid <= lap;
      if (lap) begin
        r_lap_count <= r_count;
      end
    end
  end

  assign count     = r_count;
  assign overflow  = r_overflow;
  assign lap_count = r_lap_count;
  assign lap_valid = r_lap_valid;

endmodule
